shift_sched: RTL
================

SHIFT_SCHED -- requirements
Module: shift_sched

Interface
REQ-001 Parameter W, default 8, data width in bits; SHALL be a power of two, at least 2.
REQ-002 Parameter AW, default 3, rotate-amount width; SHALL equal log2(W).
REQ-003 clk  input  1  single clock; all state SHALL change on the rising edge only.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req0_valid  input  1  channel 0 request present.
REQ-006 req0_ready  output  1  channel 0 request accepted this cycle.
REQ-007 req0_d  input  W  channel 0 operand.
REQ-008 req0_c  input  AW  channel 0 rotate amount.
REQ-009 req1_valid, req1_ready, req1_d, req1_c  same directions and widths as channel 0, for channel 1.
REQ-010 out_valid  output  1  result register holds a result.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out  output  W  rotated result.
REQ-013 out_id  output  1  channel that produced the result (0 or 1).

Function
REQ-014 Rotate rule: out[i] SHALL equal d[(i+c) mod W] for every bit i (rotate right by c); c=0 passes d through unchanged.
REQ-015 A transfer on channel k SHALL occur in any cycle where reqk_valid and reqk_ready are both 1.
REQ-016 Slot state: two states. EMPTY means out_valid=0. FULL means out_valid=1.
REQ-017 The slot SHALL be free when the state is EMPTY, or when it is FULL and out_ready=1.
REQ-018 At most one reqk_ready SHALL be 1 in any cycle.
REQ-019 reqk_ready SHALL be 1 only when all three hold: the slot is free, reqk_valid=1, and channel k holds the grant.
REQ-020 Grant: when only one channel is valid, that channel SHALL hold the grant.
REQ-021 Grant: when both channels are valid, the grant SHALL go to the channel other than the last-served one (round-robin, see REQ-031).
REQ-022 The last-served pointer SHALL update only on an accepted transfer.
REQ-023 Latency: a transfer in cycle N SHALL produce out_valid=1 in cycle N+1, with out and out_id set for that request.
REQ-024 FULL with out_ready=1 and a new transfer SHALL load the new result back-to-back and stay FULL, giving full throughput.
REQ-025 FULL with out_ready=1 and no transfer SHALL go to EMPTY.
REQ-026 FULL with out_ready=0 SHALL hold out, out_id and out_valid stable, and SHALL keep both reqk_ready at 0.
REQ-027 EMPTY with no transfer SHALL stay EMPTY.
REQ-028 reqk_ready SHALL be combinational from the valids, out_ready and state; it SHALL NOT depend on reqk_d or reqk_c.

Reset
REQ-029 rst_n=0 SHALL, asynchronously, set out_valid=0, out=0 and out_id=0, with state EMPTY.
REQ-030 rst_n=0 SHALL, asynchronously, set last-served to channel 1, so channel 0 wins the first contention. An in-flight result SHALL be discarded. reqk_ready SHALL be 0 while rst_n=0.

Configuration
REQ-031 Macro SHIFT_SCHED_RR_EN: when defined, grant SHALL be round-robin as in REQ-021.
REQ-032 When SHIFT_SCHED_RR_EN is undefined, grant SHALL be fixed priority, with channel 0 always winning contention. The last-served pointer SHALL then be absent and all other behaviour SHALL be unchanged.

Verification
REQ-033 req0 d=8'h96, c=3, with out_ready=1 -> one cycle later out_valid=1, out=8'hD2, out_id=0.
REQ-034 req1 d=8'h01, c=7, then d=8'hA5, c=0, in consecutive cycles, with out_ready=1 -> out=8'h02 then 8'hA5 on consecutive cycles, out_id=1 both times.
REQ-035 Both channels valid continuously, out_ready=1, RR_EN defined -> out_id sequence 0,1,0,1. With RR_EN undefined -> out_id sequence 0,0,0,0, and req1_ready stays 0.
REQ-036 Result pending with out_ready=0 for 3 cycles while req0 is valid -> out is stable and req0_ready=0 throughout; on the first cycle with out_ready=1, req0 transfers and its result appears on the next cycle.
REQ-037 rst_n pulsed low while FULL -> out_valid=0, out=0 and out_id=0 immediately. After release, with both channels valid, channel 0 is granted first.
REQ-038 Exhaustive sweep of c=0..7 on d=8'h80 -> out = 8'h80 >> c for each c, with no data wrap beyond bit 0.

Source files
------------

// File: rtl/shift_sched.sv
// shift_sched: two-channel rotate-right scheduler with a single result slot.
// Each accepted request (d, c) produces d rotated right by c one cycle later.
// Arbitration happens between the two request channels.
// Configuration: define SHIFT_SCHED_RR_EN for round-robin grant. Otherwise
// grant is fixed priority, and channel 0 always wins contention.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   req0_valid/ready/d/c    channel 0 request handshake, operand, rotate amount
//   req1_valid/ready/d/c    channel 1 request handshake, operand, rotate amount
//   out_valid/out_ready     result handshake
//   out, out_id             rotated result and the channel that produced it
module shift_sched #(
  parameter int unsigned W  = 8,
  parameter int unsigned AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [W-1:0]  req0_d,
  input  logic [AW-1:0] req0_c,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [W-1:0]  req1_d,
  input  logic [AW-1:0] req1_c,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out,
  output logic          out_id
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   out_q, out_d;
  logic           id_q, id_d;
  logic           slot_free;
  logic           gnt1;
  logic           xfer;
`ifdef SHIFT_SCHED_RR_EN
  logic           last_q, last_d;
`endif

  // Rotate right: bit i takes d[(i+c) mod W]. This is the low half of {d,d} >> c.
  function automatic logic [W-1:0] rotr(input logic [W-1:0] d, input logic [AW-1:0] c);
    logic [2*W-1:0] dd;
    dd = {d, d} >> c;
    return dd[W-1:0];
  endfunction

  // State and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      out_q   <= '0;
      id_q    <= 1'b0;
`ifdef SHIFT_SCHED_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      id_q    <= id_d;
`ifdef SHIFT_SCHED_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  // Grant, ready, and next-state logic
  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    id_d       = id_q;
`ifdef SHIFT_SCHED_RR_EN
    last_d     = last_q;
`endif
    req0_ready = 1'b0;
    req1_ready = 1'b0;

    slot_free = (state_q == EMPTY) || out_ready;

`ifdef SHIFT_SCHED_RR_EN
    // When both channels are valid, the grant goes to the channel that was not served last.
    gnt1 = req1_valid && (!req0_valid || !last_q);
`else
    gnt1 = req1_valid && !req0_valid;
`endif

    // Ready is held low while reset is asserted, even though the reset itself is asynchronous.
    if (rst_n && slot_free) begin
      req0_ready = req0_valid && !gnt1;
      req1_ready = req1_valid && gnt1;
    end
    xfer = req0_ready || req1_ready;

    case (state_q)
      EMPTY:   if (xfer) state_d = FULL;
      FULL:    if (out_ready && !xfer) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase

    if (xfer) begin
      out_d = req1_ready ? rotr(req1_d, req1_c) : rotr(req0_d, req0_c);
      id_d  = req1_ready;
`ifdef SHIFT_SCHED_RR_EN
      last_d = req1_ready;
`endif
    end
  end

  assign out_valid = (state_q == FULL);
  assign out       = out_q;
  assign out_id    = id_q;

endmodule
